serial_alu_seq: RTL and testbench
=================================

# serial_alu_seq

Sequencer for the bit-serial 16-bit ALU built from the NOR-gate library: one full-adder slice plus the logic-gate cells, with a 16-way mux selecting operand bits and a 16-way demux steering result bits. It latches two 16-bit operands and an opcode, then walks the 4-bit select index from bit 0 to bit 15, one bit per clock. It holds the ripple carry in a flip-flop between bits and presents the assembled result with a start/busy/done handshake. It sits between the instruction decode logic and the serial datapath.

## Interface
- No parameters. Width is fixed at 16 to match the 16-way mux/demux; the select index is 4 bits.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; accepted only in IDLE.
- op  input  3  opcode, sampled with start.
- a  input  16  operand A, sampled with start.
- b  input  16  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is final.
- sl  output  4  current bit index; drives the external mux16/demux16 select lines.
- bit_we  output  1  high in RUN; write strobe for the demux-steered result bit.
- bit_out  output  1  result bit for index sl in the current cycle.
- result  output  16  result register.
- cout  output  1  final carry; 1 = no borrow for SUB.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after bit 15.
  - DONE -> IDLE unconditionally.
- On accept:
  - Latch a, b and op into internal registers.
  - Set sl=0 and clear result.
  - Carry preset: 1 for SUB, 0 for all other opcodes.
- Opcodes, applied per bit i using the latched operands:
  - 000 ADD: a+b+c.
  - 001 SUB: a+~b+c.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOR.
  - 110 NAND.
  - 111 NOT a (b ignored).
- Each RUN cycle:
  - bit_out = f(a[sl], b[sl], carry).
  - result[sl] <= bit_out.
  - carry <= full-adder carry for ADD/SUB, held at 0 otherwise.
  - sl <= sl+1.
- sl wraps 15 -> 0 on entering DONE. sl=0 in IDLE and DONE.
- cout is loaded from the final carry on entering DONE. It is forced 0 for logic opcodes and held until the next accept.
- result holds its value through DONE and IDLE until the next accept.
- start during RUN or DONE is ignored; no queuing.
- Changes on a, b or op after accept have no effect on the operation in progress.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1..16: RUN, busy=1, bit_we=1, sl = cycle-1.
- Cycle 17: DONE, done=1, busy=0; result and cout are final.
- Cycle 18: IDLE. The earliest next accept has start=1 in cycle 18, giving a throughput of one operation per 18 cycles.
- bit_out is combinational from the latched operands, sl and carry. It is valid within the RUN cycle it belongs to and is 0 outside RUN.
- Reset values: state IDLE, busy=0, done=0, bit_we=0, sl=0, bit_out=0, result=0x0000, cout=0, carry=0.
- rst asserted in any state, including mid-RUN, returns every register to its reset value on the next edge.
  - The partial result is discarded and no done pulse is produced.
  - rst overrides a simultaneous start.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: three extra outputs, each 1 bit, updated on entering DONE, held until the next accept, and reset to 0.
  - zf: result==0.
  - nf: result[15].
  - vf: for ADD/SUB, the carry into bit 15 XOR the carry out of bit 15; for logic opcodes, 0.
- SERIAL_ALU_FLAGS_EN undefined: zf, nf and vf ports and their logic are absent; all other behaviour is identical.

## Test plan
- ADD a=0x1234, b=0x0FCD -> sl counts 0..15 over cycles 1..16; done in cycle 17; result=0x2201, cout=0.
- ADD a=0xFFFF, b=0x0001 -> result=0x0000, cout=1. With SERIAL_ALU_FLAGS_EN: zf=1, vf=0.
- SUB a=0x0005, b=0x0007 -> result=0xFFFE, cout=0, nf=1. ADD a=0x7FFF, b=0x0001 -> result=0x8000, vf=1.
- XOR a=0xAAAA, b=0x0F0F -> result=0xA5A5. NOT a=0x00FF -> 0xFF00. Both give cout=0.
- Hold start=1 continuously -> accepts at cycles 0 and 18 only. Changing a and b in cycle 5 does not alter the first result.
- rst pulse in cycle 8 of an ADD -> next cycle: IDLE, result=0x0000, busy=0, sl=0; no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial 16-bit ALU sequencer: latches operands/opcode, walks sl 0..15 with a held ripple carry.
// Optional SERIAL_ALU_FLAGS_EN adds zf/nf/vf status outputs.
module serial_alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [3:0]  sl,
    output logic        bit_we,
    output logic        bit_out,
    output logic [15:0] result,
    output logic        cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic        zf,
    output logic        nf,
    output logic        vf
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_NOT
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  sl_q, sl_d;
    logic        carry_q, carry_d;
    logic        cout_q, cout_d;
    logic        zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;

    logic a_bit, b_bit, b_eff, fa_sum, fa_carry, slice_bit, is_arith;

    // One full-adder slice plus the gate cells, fed by the mux16-selected operand bits.
    always_comb begin
        a_bit    = a_q[sl_q];
        b_bit    = b_q[sl_q];
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_eff    = (op_q == OP_SUB) ? ~b_bit : b_bit;
        fa_sum   = a_bit ^ b_eff ^ carry_q;
        fa_carry = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
        case (op_q)
            OP_ADD, OP_SUB: slice_bit = fa_sum;
            OP_AND:         slice_bit = a_bit & b_bit;
            OP_OR:          slice_bit = a_bit | b_bit;
            OP_XOR:         slice_bit = a_bit ^ b_bit;
            OP_NOR:         slice_bit = ~(a_bit | b_bit);
            OP_NAND:        slice_bit = ~(a_bit & b_bit);
            OP_NOT:         slice_bit = ~a_bit;
            default:        slice_bit = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every *_d starts from its *_q so no path through this block leaves a latch.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        sl_d     = sl_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        vf_d     = vf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    op_d     = op_e'(op);
                    a_d      = a;
                    b_d      = b;
                    result_d = 16'h0000;
                    sl_d     = 4'd0;
                    carry_d  = (op_e'(op) == OP_SUB);
                    cout_d   = 1'b0;
                    zf_d     = 1'b0;
                    nf_d     = 1'b0;
                    vf_d     = 1'b0;
                end
            end
            ST_RUN: begin
                result_d[sl_q] = slice_bit;
                carry_d        = is_arith & fa_carry;
                sl_d           = sl_q + 4'd1;
                if (sl_q == 4'd15) begin
                    state_d = ST_DONE;
                    cout_d  = is_arith & fa_carry;
                    zf_d    = (result_d == 16'h0000);
                    nf_d    = result_d[15];
                    // carry_q is the carry into bit 15 in this cycle.
                    vf_d    = is_arith & (carry_q ^ fa_carry);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
            sl_q     <= 4'd0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            sl_q     <= sl_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
            vf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            nf_q <= nf_d;
            vf_q <= vf_d;
        end
    end

    assign zf = zf_q;
    assign nf = nf_q;
    assign vf = vf_q;
`else
    // Flag logic collapses to constants when the status outputs are not built.
    assign zf_q = 1'b0;
    assign nf_q = 1'b0;
    assign vf_q = 1'b0;

    logic unused_flags;
    assign unused_flags = zf_d ^ nf_d ^ vf_d;
`endif

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign bit_we  = (state_q == ST_RUN);
    assign bit_out = (state_q == ST_RUN) & slice_bit;
    assign sl      = sl_q;
    assign result  = result_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: directed operations with a scoreboard of expected results.
// Flag checks are compiled in when SERIAL_ALU_FLAGS_EN is defined.
module tb_serial_alu_seq;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [3:0]  sl;
    logic        bit_we;
    logic        bit_out;
    logic [15:0] result;
    logic        cout;
`ifdef SERIAL_ALU_FLAGS_EN
    logic        zf, nf, vf;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    serial_alu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sl      (sl),
        .bit_we  (bit_we),
        .bit_out (bit_out),
        .result  (result),
        .cout    (cout)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .zf      (zf),
        .nf      (nf),
        .vf      (vf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, independent of the bit-serial walk.
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [16:0] s;
        e = '0;
        case (o)
            3'd0: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[15:0];
                e.c   = s[16];
                e.v   = (x[15] == y[15]) && (e.res[15] != x[15]);
            end
            3'd1: begin
                s     = {1'b0, x} + {1'b0, ~y} + 17'd1;
                e.res = s[15:0];
                e.c   = s[16];
                e.v   = (x[15] != y[15]) && (e.res[15] != x[15]);
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = x ^ y;
            3'd5: e.res = ~(x | y);
            3'd6: e.res = ~(x & y);
            default: e.res = ~x;
        endcase
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    // Called at cycle 0 (just after an edge, DUT idle); returns at cycle 18.
    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input bit keep_start, input int chg_cyc,
                          input logic [15:0] nx, input logic [15:0] ny);
        exp_t e;
        exp_t cur;
        cur = model(o, x, y);
        exp_q.push_back(cur);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (!keep_start && c == 1) start = 1'b0;
            if (c == chg_cyc) begin
                a = nx;
                b = ny;
            end
            check($sformatf("busy_c%0d", c), {15'd0, busy}, 16'd1);
            check($sformatf("done_c%0d", c), {15'd0, done}, 16'd0);
            check($sformatf("bit_we_c%0d", c), {15'd0, bit_we}, 16'd1);
            check($sformatf("sl_c%0d", c), {12'd0, sl}, 16'(c - 1));
            check($sformatf("bit_out_c%0d", c), {15'd0, bit_out}, {15'd0, cur.res[c-1]});
        end
        @(posedge clk); #1;
        check("done_c17", {15'd0, done}, 16'd1);
        check("busy_c17", {15'd0, busy}, 16'd0);
        check("sl_c17", {12'd0, sl}, 16'd0);
        check("bit_out_c17", {15'd0, bit_out}, 16'd0);
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("result_op%0d", o), result, e.res);
            check($sformatf("cout_op%0d", o), {15'd0, cout}, {15'd0, e.c});
`ifdef SERIAL_ALU_FLAGS_EN
            check($sformatf("zf_op%0d", o), {15'd0, zf}, {15'd0, e.z});
            check($sformatf("nf_op%0d", o), {15'd0, nf}, {15'd0, e.n});
            check($sformatf("vf_op%0d", o), {15'd0, vf}, {15'd0, e.v});
`endif
        end
        @(posedge clk); #1;
        check("busy_c18", {15'd0, busy}, 16'd0);
        check("done_c18", {15'd0, done}, 16'd0);
        check("result_hold_c18", result, cur.res);
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_bit_we", {15'd0, bit_we}, 16'd0);
        check("rst_sl", {12'd0, sl}, 16'd0);
        check("rst_bit_out", {15'd0, bit_out}, 16'd0);
        check("rst_result", result, 16'h0000);
        check("rst_cout", {15'd0, cout}, 16'd0);
        rst = 1'b0;

        run_op(3'd0, 16'h1234, 16'h0FCD, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd1, 16'h0005, 16'h0007, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd4, 16'hAAAA, 16'h0F0F, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd7, 16'h00FF, 16'h1234, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd3, 16'hF000, 16'h000F, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd5, 16'hF000, 16'h000F, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd6, 16'hFF00, 16'h0FF0, 1'b0, -1, 16'h0, 16'h0);
        run_op(3'd1, 16'h8000, 16'h0001, 1'b0, -1, 16'h0, 16'h0);

        // start held high throughout: second accept lands on cycle 18, operand change mid-run ignored.
        run_op(3'd0, 16'h1111, 16'h2222, 1'b1, 5, 16'hDEAD, 16'hBEEF);
        run_op(3'd0, 16'hDEAD, 16'hBEEF, 1'b1, -1, 16'h0, 16'h0);
        start = 1'b0;
        @(posedge clk); #1;
        check("held_start_released_idle", {15'd0, busy}, 16'd0);

        // Reset during cycle 8 of an ADD aborts it with no done pulse.
        op    = 3'd0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_sl", {12'd0, sl}, 16'd0);
        check("abort_result", result, 16'h0000);
        check("abort_bit_we", {15'd0, bit_we}, 16'd0);
        check("abort_bit_out", {15'd0, bit_out}, 16'd0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 16'(done_seen), 16'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_over_start_busy", {15'd0, busy}, 16'd0);

        run_op(3'd0, 16'h1234, 16'h0FCD, 1'b0, -1, 16'h0, 16'h0);

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
